sopc_top_timer_host: RTL and testbench
======================================

// Module: sopc_top_timer_host
// PURPOSE
//  Avalon-MM initiator that owns and services the SOPC interval timer (16-bit slave, 6-word map).
//  Programs the 32-bit period, starts the timer and answers its IRQ by clearing the timeout flag.
//  Counts ticks and returns counter snapshots on request. Sits between local control logic and the timer s1 port.
//  Timer map: 0 STATUS{RUN,TO} (write clears TO), 1 CONTROL{STOP,START,CONT,ITO}, 2 PERIODL, 3 PERIODH,
//  4 SNAPL, 5 SNAPH (a write latches the snapshot).
// PARAMETERS
//  TICK_W          16          width of tick_count
//  DEFAULT_PERIOD  32'd99999   period used when cfg_period == 0
// PORTS
//  clk            in   1       single clock; all logic on posedge
//  reset_n        in   1       asynchronous, active-low reset
//  avm_address    out  3       timer word address
//  avm_chipselect out  1       bus cycle valid
//  avm_write_n    out  1       0 = write, 1 = read (when chipselect = 1)
//  avm_writedata  out  16      write data
//  avm_readdata   in   16      read data, fixed latency 1, no waitrequest
//  timer_irq      in   1       timer interrupt, level, active-high
//  cfg_start      in   1       pulse: program period and start timer
//  cfg_stop       in   1       pulse: stop timer
//  cfg_period     in   32      period, sampled on an accepted cfg_start
//  cfg_continuous in   1       sampled with cfg_start: 1 = free-run, 0 = one-shot
//  snap_req       in   1       pulse: capture the live counter value
//  busy           out  1       FSM is not in IDLE or ARMED
//  armed          out  1       timer running under host control
//  tick_pulse     out  1       one cycle per serviced timeout
//  tick_count     out  TICK_W  serviced timeouts since the last start; wraps modulo 2^TICK_W
//  snap_value     out  32      last snapshot {SNAPH,SNAPL}
//  snap_valid     out  1       one-cycle pulse when snap_value updates
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: chipselect 0, write_n 1, address 0, writedata 0; all status outputs 0; FSM in IDLE.
//  - reset_n low mid-transaction: aborts immediately to reset state. No bus cycle is completed.
//  - One bus cycle per state: chipselect = 1 for exactly 1 clk.
//  - Read: address is presented in cycle N; readdata is sampled in cycle N+1.
//  - States:
//    IDLE     -> WR_PL on cfg_start. All other requests are ignored.
//    WR_PL    write addr2 = per[15:0]; then WR_PH.
//    WR_PH    write addr3 = per[31:16]; then WR_CTRL.
//    WR_CTRL  write addr1 = {0,1,cont,1}; clear tick_count; then ARMED.
//    ARMED    bus idle. Priority: cfg_stop > cfg_start > timer_irq > snap_req.
//             cfg_stop -> WR_STOP; cfg_start -> WR_PL (restart); timer_irq -> CLR; snap_req -> SN_WR.
//    CLR      write addr0 = 0; tick_count++, tick_pulse = 1; then RD_ST.
//    RD_ST    read addr0; then RD_CAP.
//    RD_CAP   sample readdata[1] (RUN). RUN = 0 or cont = 0 -> IDLE, armed = 0; else -> ARMED.
//    SN_WR    write addr4; then SN_L.
//    SN_L     read addr4; then SN_H.
//    SN_H     read addr5; capture readdata -> snap_value[15:0]; then SN_CAP.
//    SN_CAP   capture readdata -> snap_value[31:16]; snap_valid = 1; then ARMED.
//    WR_STOP  write addr1 = 4'b1000 (STOP=1, ITO=0); armed = 0; then IDLE.
//  - per = (cfg_period == 0) ? DEFAULT_PERIOD : cfg_period. per and cont are latched on the accepted cfg_start.
//  - Pulses arriving while busy are dropped, not queued.
//    Exception: timer_irq is a level and is serviced on the next entry to ARMED.
//  - Ordering rules:
//    - Period writes always precede the CONTROL write, because a period write stops the timer.
//    - The TO clear takes effect before RD_ST, so timer_irq is low by the time ARMED is re-entered.
//  - tick_count: TICK_W-bit unsigned; 2^TICK_W-1 + 1 -> 0; no saturation.
// TESTING
//  1. Reset, then cfg_start, per = 32'h0001_0004, cont = 1
//     -> writes (2,0004), (3,0001), (1,0007) on consecutive clks; armed = 1.
//  2. Timer model raises irq -> next bus cycles: write addr0, read addr0; tick_pulse = 1; tick_count = 1; stays ARMED.
//  3. One-shot (cont = 0), irq -> after RD_CAP: armed = 0, IDLE, control word (1,0005) was written at start.
//  4. snap_req while ARMED, model counter = 32'h0002_1234
//     -> write addr4, read 4, read 5; snap_value = 32'h0002_1234; snap_valid pulses for 1 clk.
//  5. cfg_period = 0 -> writes (2,869F), (3,0001); cfg_stop together with timer_irq in ARMED -> write (1,0008) only; IDLE.
//  6. TICK_W = 2, five irqs serviced -> tick_count 1,2,3,0,1; reset_n low during SN_L
//     -> outputs at reset values next clk; no snap_valid.

Source files
------------

// File: rtl/sopc_top_timer_host.sv
// Avalon-MM initiator that programs, starts, services and snapshots the SOPC interval timer.
// Bus outputs are decoded from the next state, so each registered bus cycle lines up with its FSM state.
module sopc_top_timer_host #(
    parameter int          TICK_W         = 16,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd99999
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              timer_irq,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              snap_req,
    output logic              busy,
    output logic              armed,
    output logic              tick_pulse,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_ARMED, S_CLR, S_RD_ST,
        S_RD_CAP, S_SN_WR, S_SN_L, S_SN_H, S_SN_CAP, S_WR_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       per_q, per_d;
    logic              cont_q, cont_d;
    logic [15:0]       snap_lo_q, snap_lo_d;
    logic [2:0]        avm_address_q, avm_address_d;
    logic              avm_chipselect_q, avm_chipselect_d;
    logic              avm_write_n_q, avm_write_n_d;
    logic [15:0]       avm_writedata_q, avm_writedata_d;
    logic              busy_q, busy_d;
    logic              armed_q, armed_d;
    logic              tick_pulse_q, tick_pulse_d;
    logic [TICK_W-1:0] tick_count_q, tick_count_d;
    logic [31:0]       snap_value_q, snap_value_d;
    logic              snap_valid_q, snap_valid_d;
    logic              accept_s;

    // Next-state, latched configuration and registered output decode
    always_comb begin
        state_d      = state_q;
        per_d        = per_q;
        cont_d       = cont_q;
        snap_lo_d    = snap_lo_q;
        snap_value_d = snap_value_q;
        snap_valid_d = 1'b0;
        tick_count_d = tick_count_q;
        accept_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d  = S_WR_PL;
                    accept_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARMED: begin
                if (cfg_stop) begin
                    state_d = S_WR_STOP;
                end else if (cfg_start) begin
                    state_d  = S_WR_PL;
                    accept_s = 1'b1;
                end else if (timer_irq) begin
                    state_d = S_CLR;
                end else if (snap_req) begin
                    state_d = S_SN_WR;
                end else begin
                    state_d = S_ARMED;
                end
            end
            S_WR_PL:   state_d = S_WR_PH;
            S_WR_PH:   state_d = S_WR_CTRL;
            S_WR_CTRL: state_d = S_ARMED;
            S_CLR:     state_d = S_RD_ST;
            S_RD_ST:   state_d = S_RD_CAP;
            S_RD_CAP: begin
                if (!avm_readdata[1] || !cont_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ARMED;
                end
            end
            S_SN_WR:   state_d = S_SN_L;
            S_SN_L:    state_d = S_SN_H;
            S_SN_H: begin
                snap_lo_d = avm_readdata;
                state_d   = S_SN_CAP;
            end
            S_SN_CAP: begin
                snap_value_d = {avm_readdata, snap_lo_q};
                snap_valid_d = 1'b1;
                state_d      = S_ARMED;
            end
            S_WR_STOP: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (accept_s) begin
            per_d  = (cfg_period == 32'd0) ? DEFAULT_PERIOD : cfg_period;
            cont_d = cfg_continuous;
        end else begin
            per_d  = per_q;
            cont_d = cont_q;
        end

        // Bus cycle belonging to the state being entered
        avm_chipselect_d = 1'b0;
        avm_write_n_d    = 1'b1;
        avm_address_d    = 3'd0;
        avm_writedata_d  = 16'h0000;
        tick_pulse_d     = 1'b0;
        case (state_d)
            S_WR_PL: begin
                avm_chipselect_d = 1'b1;
                avm_write_n_d    = 1'b0;
                avm_address_d    = 3'd2;
                avm_writedata_d  = per_d[15:0];
            end
            S_WR_PH: begin
                avm_chipselect_d = 1'b1;
                avm_write_n_d    = 1'b0;
                avm_address_d    = 3'd3;
                avm_writedata_d  = per_d[31:16];
            end
            S_WR_CTRL: begin
                avm_chipselect_d = 1'b1;
                avm_write_n_d    = 1'b0;
                avm_address_d    = 3'd1;
                avm_writedata_d  = {12'h000, 1'b0, 1'b1, cont_d, 1'b1};
                tick_count_d     = {TICK_W{1'b0}};
            end
            S_CLR: begin
                avm_chipselect_d = 1'b1;
                avm_write_n_d    = 1'b0;
                avm_address_d    = 3'd0;
                tick_count_d     = tick_count_q + {{(TICK_W-1){1'b0}}, 1'b1};
                tick_pulse_d     = 1'b1;
            end
            S_RD_ST: begin
                avm_chipselect_d = 1'b1;
                avm_address_d    = 3'd0;
            end
            S_SN_WR: begin
                avm_chipselect_d = 1'b1;
                avm_write_n_d    = 1'b0;
                avm_address_d    = 3'd4;
            end
            S_SN_L: begin
                avm_chipselect_d = 1'b1;
                avm_address_d    = 3'd4;
            end
            S_SN_H: begin
                avm_chipselect_d = 1'b1;
                avm_address_d    = 3'd5;
            end
            S_WR_STOP: begin
                avm_chipselect_d = 1'b1;
                avm_write_n_d    = 1'b0;
                avm_address_d    = 3'd1;
                avm_writedata_d  = 16'h0008;
            end
            default: avm_chipselect_d = 1'b0;
        endcase

        busy_d  = !(state_d inside {S_IDLE, S_ARMED});
        armed_d = state_d inside {S_ARMED, S_CLR, S_RD_ST, S_RD_CAP,
                                  S_SN_WR, S_SN_L, S_SN_H, S_SN_CAP};
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            per_q            <= 32'd0;
            cont_q           <= 1'b0;
            snap_lo_q        <= 16'h0000;
            avm_address_q    <= 3'd0;
            avm_chipselect_q <= 1'b0;
            avm_write_n_q    <= 1'b1;
            avm_writedata_q  <= 16'h0000;
            busy_q           <= 1'b0;
            armed_q          <= 1'b0;
            tick_pulse_q     <= 1'b0;
            tick_count_q     <= {TICK_W{1'b0}};
            snap_value_q     <= 32'd0;
            snap_valid_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            per_q            <= per_d;
            cont_q           <= cont_d;
            snap_lo_q        <= snap_lo_d;
            avm_address_q    <= avm_address_d;
            avm_chipselect_q <= avm_chipselect_d;
            avm_write_n_q    <= avm_write_n_d;
            avm_writedata_q  <= avm_writedata_d;
            busy_q           <= busy_d;
            armed_q          <= armed_d;
            tick_pulse_q     <= tick_pulse_d;
            tick_count_q     <= tick_count_d;
            snap_value_q     <= snap_value_d;
            snap_valid_q     <= snap_valid_d;
        end
    end

    assign avm_address    = avm_address_q;
    assign avm_chipselect = avm_chipselect_q;
    assign avm_write_n    = avm_write_n_q;
    assign avm_writedata  = avm_writedata_q;
    assign busy           = busy_q;
    assign armed          = armed_q;
    assign tick_pulse     = tick_pulse_q;
    assign tick_count     = tick_count_q;
    assign snap_value     = snap_value_q;
    assign snap_valid     = snap_valid_q;

endmodule

// File: tb/tb_sopc_top_timer_host.sv
// Bench for sopc_top_timer_host: directed vector table, random ops against a transaction-level model,
// and reset abort in the middle of a snapshot.
`timescale 1ns/1ps
module tb_sopc_top_timer_host;
    localparam int TW = 2;
    localparam int OP_START = 0, OP_IRQ = 1, OP_SNAP = 2, OP_STOP = 3, OP_STOPIRQ = 4;
    typedef logic [19:0] tr_t;

    logic clk = 1'b0, reset_n = 1'b0;
    logic [2:0] avm_address;
    logic avm_chipselect, avm_write_n;
    logic [15:0] avm_writedata, avm_readdata;
    logic timer_irq;
    logic cfg_start = 1'b0, cfg_stop = 1'b0, cfg_continuous = 1'b0, snap_req = 1'b0;
    logic [31:0] cfg_period = 32'd0;
    logic busy, armed, tick_pulse, snap_valid;
    logic [TW-1:0] tick_count;
    logic [31:0] snap_value;

    always #5 clk = ~clk;

    sopc_top_timer_host #(.TICK_W(TW), .DEFAULT_PERIOD(32'd99999)) dut (
        .clk(clk), .reset_n(reset_n),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .timer_irq(timer_irq),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_period(cfg_period),
        .cfg_continuous(cfg_continuous), .snap_req(snap_req), .busy(busy), .armed(armed),
        .tick_pulse(tick_pulse), .tick_count(tick_count), .snap_value(snap_value),
        .snap_valid(snap_valid)
    );

    // Simple timer slave: registered readdata, irq = TO & ITO
    logic [15:0] rd_q = 16'h0;
    logic t_run = 1'b0, t_to = 1'b0, t_ito = 1'b0, t_cont = 1'b0, fire_req = 1'b0;
    logic [31:0] t_per = 32'd0, t_snap = 32'd0, model_cnt = 32'd0;
    assign avm_readdata = rd_q;
    assign timer_irq    = t_to & t_ito;

    always @(posedge clk) begin
        if (fire_req) begin
            t_to <= 1'b1;
            if (!t_cont) t_run <= 1'b0;
        end
        if (avm_chipselect) begin
            if (!avm_write_n) begin
                case (avm_address)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito  <= avm_writedata[0];
                        t_cont <= avm_writedata[1];
                        if (avm_writedata[2]) t_run <= 1'b1;
                        if (avm_writedata[3]) t_run <= 1'b0;
                    end
                    3'd2: begin t_per[15:0]  <= avm_writedata; t_run <= 1'b0; end
                    3'd3: begin t_per[31:16] <= avm_writedata; t_run <= 1'b0; end
                    3'd4: t_snap <= model_cnt;
                    default: ;
                endcase
            end else begin
                case (avm_address)
                    3'd0: rd_q <= {14'd0, t_run, t_to};
                    3'd1: rd_q <= {12'd0, 1'b0, 1'b0, t_cont, t_ito};
                    3'd2: rd_q <= t_per[15:0];
                    3'd3: rd_q <= t_per[31:16];
                    3'd4: rd_q <= t_snap[15:0];
                    3'd5: rd_q <= t_snap[31:16];
                    default: rd_q <= 16'h0;
                endcase
            end
        end
    end

    function automatic tr_t norm(input logic wn, input logic [2:0] a, input logic [15:0] d);
        return (wn || a == 3'd4) ? {wn, a, 16'h0000} : {wn, a, d};
    endfunction
    function automatic tr_t W(input logic [2:0] a, input logic [15:0] d);
        return norm(1'b0, a, d);
    endfunction
    function automatic tr_t R(input logic [2:0] a);
        return norm(1'b1, a, 16'h0000);
    endfunction

    // Bus monitor
    tr_t bus_log[$];
    int  bus_cyc[$];
    int  cyc = 0, n_tick = 0, n_snapv = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_chipselect) begin
            bus_log.push_back(norm(avm_write_n, avm_address, avm_writedata));
            bus_cyc.push_back(cyc);
        end
        if (tick_pulse) n_tick <= n_tick + 1;
        if (snap_valid) n_snapv <= n_snapv + 1;
    end

    int checks = 0, errors = 0;
    int b0, t0, s0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input int op, input logic [31:0] per, input logic cont, input logic [31:0] cnt);
        @(negedge clk);
        b0 = bus_log.size(); t0 = n_tick; s0 = n_snapv;
        model_cnt = cnt; cfg_period = per; cfg_continuous = cont;
        case (op)
            OP_START: cfg_start = 1'b1;
            OP_SNAP:  snap_req  = 1'b1;
            OP_STOP:  cfg_stop  = 1'b1;
            default:  fire_req  = 1'b1;
        endcase
        @(negedge clk);
        cfg_start = 1'b0; snap_req = 1'b0; fire_req = 1'b0;
        cfg_stop = (op == OP_STOPIRQ);
        @(negedge clk);
        cfg_stop = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic check_op(input string nm, input tr_t e[$], input logic ea, input logic [TW-1:0] et,
                            input int ept, input int eps, input logic [31:0] es);
        int m;
        chk({nm, " nbus"}, bus_log.size() - b0, e.size());
        for (int i = 0; i < e.size(); i++)
            chk($sformatf("%s bus%0d", nm, i), (b0 + i < bus_log.size()) ? bus_log[b0 + i] : 20'hFFFFF, e[i]);
        m = (e.size() < 3) ? e.size() : 3;
        if (m > 0 && bus_log.size() >= b0 + m)
            chk({nm, " consecutive"}, bus_cyc[b0 + m - 1] - bus_cyc[b0], m - 1);
        chk({nm, " armed"}, armed, ea);
        chk({nm, " busy"}, busy, 1'b0);
        chk({nm, " tick_count"}, tick_count, et);
        chk({nm, " tick_pulses"}, n_tick - t0, ept);
        chk({nm, " snap_valids"}, n_snapv - s0, eps);
        chk({nm, " snap_value"}, snap_value, es);
        if (ept > 0) chk({nm, " irq_cleared"}, timer_irq, 1'b0);
    endtask

    typedef struct {
        int op; logic [31:0] per; logic cont; logic [31:0] cnt;
        int n; tr_t b0; tr_t b1; tr_t b2;
        logic ea; logic [TW-1:0] et; int ept; int eps; logic [31:0] es;
    } vec_t;
    vec_t tbl[11];

    // Reference model state (transaction level)
    logic arm_m, cont_m, pend_m;
    int   tick_m;
    logic [31:0] snap_m;

    task automatic model_op(input int op, input logic [31:0] per, input logic cont, input logic [31:0] cnt,
                            output tr_t e[$], output int ept, output int eps);
        logic [31:0] pe;
        e.delete(); ept = 0; eps = 0;
        if (op == OP_START) begin
            pe = (per == 32'd0) ? 32'd99999 : per;
            e.push_back(W(3'd2, pe[15:0]));
            e.push_back(W(3'd3, pe[31:16]));
            e.push_back(W(3'd1, cont ? 16'h0007 : 16'h0005));
            tick_m = 0; cont_m = cont; arm_m = 1'b1;
            if (pend_m) begin
                e.push_back(W(3'd0, 16'h0)); e.push_back(R(3'd0));
                tick_m++; ept = 1; pend_m = 1'b0; arm_m = cont;
            end
        end else if (!arm_m) begin
            if (op == OP_IRQ || op == OP_STOPIRQ) pend_m = 1'b1;
        end else begin
            case (op)
                OP_IRQ: begin
                    e.push_back(W(3'd0, 16'h0)); e.push_back(R(3'd0));
                    tick_m++; ept = 1; arm_m = cont_m;
                end
                OP_SNAP: begin
                    e.push_back(W(3'd4, 16'h0)); e.push_back(R(3'd4)); e.push_back(R(3'd5));
                    snap_m = cnt; eps = 1;
                end
                default: begin
                    e.push_back(W(3'd1, 16'h0008)); arm_m = 1'b0;
                    if (op == OP_STOPIRQ) pend_m = 1'b1;
                end
            endcase
        end
    endtask

    initial begin
        tr_t e[$];
        int op, ept, eps;
        logic [31:0] per, cnt;
        logic cont;

        tbl[0]  = '{OP_START, 32'h0001_0004, 1'b1, 32'd0, 3, W(2, 16'h0004), W(3, 16'h0001), W(1, 16'h0007), 1'b1, 2'd0, 0, 0, 32'd0};
        tbl[1]  = '{OP_IRQ,   32'd0, 1'b0, 32'd0, 2, W(0, 16'h0), R(0), 20'h0, 1'b1, 2'd1, 1, 0, 32'd0};
        tbl[2]  = '{OP_SNAP,  32'd0, 1'b0, 32'h0002_1234, 3, W(4, 16'h0), R(4), R(5), 1'b1, 2'd1, 0, 1, 32'h0002_1234};
        tbl[3]  = '{OP_IRQ,   32'd0, 1'b0, 32'd0, 2, W(0, 16'h0), R(0), 20'h0, 1'b1, 2'd2, 1, 0, 32'h0002_1234};
        tbl[4]  = '{OP_IRQ,   32'd0, 1'b0, 32'd0, 2, W(0, 16'h0), R(0), 20'h0, 1'b1, 2'd3, 1, 0, 32'h0002_1234};
        tbl[5]  = '{OP_IRQ,   32'd0, 1'b0, 32'd0, 2, W(0, 16'h0), R(0), 20'h0, 1'b1, 2'd0, 1, 0, 32'h0002_1234};
        tbl[6]  = '{OP_IRQ,   32'd0, 1'b0, 32'd0, 2, W(0, 16'h0), R(0), 20'h0, 1'b1, 2'd1, 1, 0, 32'h0002_1234};
        tbl[7]  = '{OP_START, 32'd0, 1'b0, 32'd0, 3, W(2, 16'h869F), W(3, 16'h0001), W(1, 16'h0005), 1'b1, 2'd0, 0, 0, 32'h0002_1234};
        tbl[8]  = '{OP_IRQ,   32'd0, 1'b0, 32'd0, 2, W(0, 16'h0), R(0), 20'h0, 1'b0, 2'd1, 1, 0, 32'h0002_1234};
        tbl[9]  = '{OP_START, 32'h0000_00FF, 1'b1, 32'd0, 3, W(2, 16'h00FF), W(3, 16'h0000), W(1, 16'h0007), 1'b1, 2'd0, 0, 0, 32'h0002_1234};
        tbl[10] = '{OP_STOPIRQ, 32'd0, 1'b0, 32'd0, 1, W(1, 16'h0008), 20'h0, 20'h0, 1'b0, 2'd0, 0, 0, 32'h0002_1234};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst chipselect", avm_chipselect, 1'b0);
        chk("rst write_n", avm_write_n, 1'b1);
        chk("rst address", avm_address, 3'd0);
        chk("rst writedata", avm_writedata, 16'h0);
        chk("rst status", {busy, armed, tick_pulse, snap_valid, tick_count}, 0);
        chk("rst snap_value", snap_value, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].op, tbl[i].per, tbl[i].cont, tbl[i].cnt);
            e.delete();
            if (tbl[i].n > 0) e.push_back(tbl[i].b0);
            if (tbl[i].n > 1) e.push_back(tbl[i].b1);
            if (tbl[i].n > 2) e.push_back(tbl[i].b2);
            check_op($sformatf("vec%0d", i), e, tbl[i].ea, tbl[i].et, tbl[i].ept, tbl[i].eps, tbl[i].es);
        end

        // Random ops against the model; the last vector left a timeout pending
        arm_m = 1'b0; cont_m = 1'b1; pend_m = 1'b1; tick_m = 0; snap_m = 32'h0002_1234;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 4);
            if (!arm_m && $urandom_range(0, 1) == 0) op = OP_START;
            per  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            cont = 1'($urandom_range(0, 1));
            cnt  = $urandom;
            model_op(op, per, cont, cnt, e, ept, eps);
            run_op(op, per, cont, cnt);
            check_op($sformatf("rnd%0d op%0d", i, op), e, arm_m, TW'(tick_m % (1 << TW)), ept, eps, snap_m);
        end

        // Reset asserted while the snapshot low word is being read
        if (!arm_m) begin
            model_op(OP_START, 32'h0000_0100, 1'b1, 32'd0, e, ept, eps);
            run_op(OP_START, 32'h0000_0100, 1'b1, 32'd0);
            check_op("prearm", e, arm_m, TW'(tick_m % (1 << TW)), ept, eps, snap_m);
        end
        @(negedge clk);
        s0 = n_snapv; model_cnt = 32'hDEAD_BEEF; snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        @(negedge clk);
        chk("in SN_L", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b1, 3'd4});
        reset_n = 1'b0;
        #1;
        chk("abort chipselect", avm_chipselect, 1'b0);
        chk("abort bus", {avm_write_n, avm_address, avm_writedata}, {1'b1, 3'd0, 16'h0});
        chk("abort status", {busy, armed, tick_pulse, snap_valid, tick_count}, 0);
        chk("abort snap_value", snap_value, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort no snap_valid", n_snapv - s0, 0);
        chk("abort idle", {busy, armed, avm_chipselect}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
